// File: rtl/rank_pkg.sv
// Shared types and constants for the ranked score buffer.
// The FSM state type, index width, comparator timeout and default geometry.
package rank_pkg;

    localparam int IDX_W        = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_QUANTITY = 10;

    localparam logic [IDX_W-1:0] TIMEOUT = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/rank_insert_shift.sv
// Combinational insert: entries at or above idx move down one slot and score lands at idx.
// Zero latency; when wr_en is low the buffer passes through unchanged.
module rank_insert_shift
    import rank_pkg::*;
#(
    parameter int width    = DEF_WIDTH,
    parameter int quantity = DEF_QUANTITY
) (
    input  logic [quantity*width-1:0] buf_cur,
    input  logic [IDX_W-1:0]          idx,
    input  logic [width-1:0]          score,
    input  logic                      wr_en,
    output logic [quantity*width-1:0] buf_nxt
);

    for (genvar j = 0; j < quantity; j++) begin : g_ent
        localparam logic [IDX_W-1:0] J = IDX_W'(j);
        if (j == 0) begin : g_head
            assign buf_nxt[width-1:0] = (wr_en && idx == J) ? score : buf_cur[width-1:0];
        end else begin : g_body
            // The old last entry has no destination and falls off the end.
            assign buf_nxt[j*width +: width] =
                (!wr_en || J < idx) ? buf_cur[j*width +: width] :
                (J == idx)          ? score :
                                      buf_cur[(j-1)*width +: width];
        end
    end

endmodule

// File: rtl/rank_insert.sv
// Ranked score buffer: latches one score, asks the comparator for its rank, then inserts or drops it.
// Accept-to-done is comparator latency + 3 cycles; score_ready stays low until the FSM is back in IDLE.
module rank_insert
    import rank_pkg::*;
#(
    parameter int width    = DEF_WIDTH,
    parameter int quantity = DEF_QUANTITY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      score_valid,
    input  logic [width-1:0]          score_in,
    output logic                      score_ready,
    input  logic                      clear,
    output logic                      compare_data_rdy,
    output logic [width-1:0]          score_out,
    output logic [quantity*width-1:0] score_buffer,
    output logic [IDX_W-1:0]          compare_num,
    input  logic                      compare_rdy,
    input  logic [IDX_W-1:0]          insert_index,
    output logic                      insert_done,
    output logic                      dropped,
    output logic                      timeout
);

    localparam logic [IDX_W-1:0] QTY = IDX_W'(quantity);

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          wait_cnt;
    logic [quantity*width-1:0] buf_q, buf_nxt;
    logic                      drop_q;
    logic                      accept, cmp_hit, cmp_drop, wr_en;
    logic [IDX_W-1:0]          idx;

    assign accept   = score_valid && score_ready;
    assign cmp_hit  = (state == WAIT) && compare_rdy && !clear;
    assign cmp_drop = insert_index >= QTY;
    assign idx      = (insert_index < compare_num) ? insert_index : compare_num;
    assign wr_en    = cmp_hit && !cmp_drop;

    rank_insert_shift #(
        .width   (width),
        .quantity(quantity)
    ) u_shift (
        .buf_cur(buf_q),
        .idx    (idx),
        .score  (score_out),
        .wr_en  (wr_en),
        .buf_nxt(buf_nxt)
    );

    always_comb begin
        state_nxt        = state;
        score_ready      = 1'b0;
        compare_data_rdy = 1'b0;
        insert_done      = 1'b0;
        dropped          = 1'b0;
        timeout          = 1'b0;
        unique case (state)
            IDLE: begin
                score_ready = !clear;
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                compare_data_rdy = 1'b1;
                state_nxt        = clear ? IDLE : WAIT;
            end
            WAIT: begin
                // A flush abandons the pending score; a late answer beats the timeout.
                if (clear) begin
                    state_nxt = IDLE;
                end else if (compare_rdy) begin
                    state_nxt = DONE;
                end else if (wait_cnt == TIMEOUT) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                insert_done = 1'b1;
                dropped     = drop_q;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            buf_q       <= '0;
            compare_num <= '0;
            score_out   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (accept) score_out <= score_in;
            if (cmp_hit) drop_q <= cmp_drop;
            if (clear) begin
                buf_q       <= '0;
                compare_num <= '0;
            end else if (wr_en) begin
                buf_q       <= buf_nxt;
                compare_num <= (compare_num < QTY) ? compare_num + 1'b1 : compare_num;
            end
        end
    end

    // Slots past the valid count always present zero, whatever the storage holds.
    for (genvar j = 0; j < quantity; j++) begin : g_out
        assign score_buffer[j*width +: width] =
            (IDX_W'(j) < compare_num) ? buf_q[j*width +: width] : '0;
    end

endmodule

// File: tb/tb_rank_insert.sv
// Bench for rank_insert: drives scores and comparator answers, and scores each insert_done
// against a reference rank list queued when the score is offered.
module tb_rank_insert;

    localparam int W = 8;
    localparam int Q = 10;

    typedef struct packed {
        logic           drop;
        logic [3:0]     num;
        logic [Q*W-1:0] flat;
    } res_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           score_valid;
    logic [W-1:0]   score_in;
    logic           score_ready;
    logic           clear;
    logic           compare_data_rdy;
    logic [W-1:0]   score_out;
    logic [Q*W-1:0] score_buffer;
    logic [3:0]     compare_num;
    logic           compare_rdy;
    logic [3:0]     insert_index;
    logic           insert_done;
    logic           dropped;
    logic           timeout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc, done_cyc;

    logic [W-1:0] m_buf [Q];
    int           m_num;
    res_t         sb [$];

    rank_insert #(.width(W), .quantity(Q)) dut (
        .clk             (clk),
        .rst             (rst),
        .score_valid     (score_valid),
        .score_in        (score_in),
        .score_ready     (score_ready),
        .clear           (clear),
        .compare_data_rdy(compare_data_rdy),
        .score_out       (score_out),
        .score_buffer    (score_buffer),
        .compare_num     (compare_num),
        .compare_rdy     (compare_rdy),
        .insert_index    (insert_index),
        .insert_done     (insert_done),
        .dropped         (dropped),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int j = 0; j < Q; j++) m_buf[j] = '0;
        m_num = 0;
    endtask

    function automatic logic [Q*W-1:0] model_flat();
        logic [Q*W-1:0] f;
        for (int j = 0; j < Q; j++) f[j*W +: W] = m_buf[j];
        return f;
    endfunction

    task automatic model_insert(input logic [W-1:0] s, input int ii, output res_t e);
        int idx;
        e.drop = (ii >= Q);
        if (ii < Q) begin
            idx = (ii < m_num) ? ii : m_num;
            for (int j = Q - 1; j > idx; j--) m_buf[j] = m_buf[j-1];
            m_buf[idx] = s;
            if (m_num < Q) m_num++;
        end
        e.num  = 4'(m_num);
        e.flat = model_flat();
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic offer(input logic [W-1:0] s, output bit ok);
        bit hs;
        hs = 1'b0;
        score_valid = 1'b1;
        score_in    = s;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            hs      = score_ready;
            acc_cyc = cyc;
            @(posedge clk); #1;
        end
        score_valid = 1'b0;
        ok = hs;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clk);
            ok = compare_data_rdy;
            @(posedge clk); #1;
        end
    endtask

    task automatic answer(input logic [3:0] ii, input int lat);
        repeat (lat) begin @(posedge clk); #1; end
        compare_rdy  = 1'b1;
        insert_index = ii;
        @(posedge clk); #1;
        compare_rdy  = 1'b0;
        insert_index = '0;
    endtask

    task automatic wait_done(output res_t o, output bit ok);
        ok = 1'b0;
        o  = '0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (insert_done) begin
                ok       = 1'b1;
                o        = {dropped, compare_num, score_buffer};
                done_cyc = cyc;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic insert_one(input logic [W-1:0] s, input int ii, input int lat,
                              output res_t o, output bit ok, output int l);
        bit   ok_a, ok_b, ok_c;
        res_t e;
        offer(s, ok_a);
        model_insert(s, ii, e);
        sb.push_back(e);
        wait_req(ok_b);
        answer(4'(ii), lat);
        wait_done(o, ok_c);
        ok = ok_a && ok_b && ok_c;
        l  = done_cyc - acc_cyc;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        tests++;
        if (score_ready !== 1'b0) begin
            fails++;
            $display("FAIL clear_ready: got %b want 0", score_ready);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        @(negedge clk);
        tests++;
        if (compare_num !== 4'd0 || score_buffer !== '0) begin
            fails++;
            $display("FAIL clear_zero: got num=%0d buf=%h want num=0 buf=0", compare_num, score_buffer);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; score_valid = 1'b0; score_in = '0; clear = 1'b0;
        compare_rdy = 1'b0; insert_index = '0;
        model_clear();
        @(negedge clk);
        tests++;
        if ({score_ready, compare_data_rdy, insert_done, dropped, timeout} !== 5'b10000 ||
            compare_num !== 4'd0 || score_buffer !== '0 || score_out !== '0) begin
            fails++;
            $display("FAIL reset: got rdy/cdr/done/drop/to=%b num=%0d out=%0d buf=%h want 10000 0 0 0",
                     {score_ready, compare_data_rdy, insert_done, dropped, timeout},
                     compare_num, score_out, score_buffer);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_first_insert();
        res_t o, e; bit ok; int l;
        insert_one(8'd50, 0, 0, o, ok, l);
        e = sb.pop_front();
        tests++;
        if (!ok || o !== e) begin
            fails++;
            $display("FAIL first_insert: got %h ok=%0b want %h", o, ok, e);
        end
        tests++;
        if (l != 3) begin
            fails++;
            $display("FAIL first_latency: got %0d want 3", l);
        end
    endtask

    task automatic test_mid_insert();
        logic [W-1:0] sc [4] = '{8'd90, 8'd70, 8'd40, 8'd60};
        int           ix [4] = '{0, 1, 2, 2};
        int           lt [4] = '{1, 2, 0, 4};
        res_t o, e; bit ok; int l;
        do_clear();
        for (int k = 0; k < 4; k++) begin
            insert_one(sc[k], ix[k], lt[k], o, ok, l);
            e = sb.pop_front();
            tests++;
            if (!ok || o !== e) begin
                fails++;
                $display("FAIL mid_insert[%0d]: got %h ok=%0b want %h", k, o, ok, e);
            end
        end
        tests++;
        if (l != 7) begin
            fails++;
            $display("FAIL mid_latency: got %0d want 7", l);
        end
        tests++;
        if (score_buffer !== {48'h0, 8'd40, 8'd60, 8'd70, 8'd90} || compare_num !== 4'd4) begin
            fails++;
            $display("FAIL mid_final: got num=%0d buf=%h want num=4 buf=%h",
                     compare_num, score_buffer, {48'h0, 8'd40, 8'd60, 8'd70, 8'd90});
        end
    endtask

    task automatic test_index_clamp();
        res_t o, e; bit ok; int l;
        insert_one(8'd20, 9, 1, o, ok, l);
        e = sb.pop_front();
        tests++;
        if (!ok || o !== e || o.flat !== {40'h0, 8'd20, 8'd40, 8'd60, 8'd70, 8'd90}) begin
            fails++;
            $display("FAIL index_clamp: got %h ok=%0b want %h", o, ok, e);
        end
    endtask

    task automatic test_full_drop();
        res_t o, e; bit ok; int l;
        do_clear();
        for (int k = 0; k < Q; k++) begin
            insert_one(8'(100 - 10 * k), k, k % 3, o, ok, l);
            e = sb.pop_front();
            tests++;
            if (!ok || o !== e) begin
                fails++;
                $display("FAIL fill[%0d]: got %h ok=%0b want %h", k, o, ok, e);
            end
        end
        for (int k = 0; k < 2; k++) begin
            insert_one(8'd5, (k == 0) ? 10 : 15, 2, o, ok, l);
            e = sb.pop_front();
            tests++;
            if (!ok || o !== e || o.drop !== 1'b1 || o.num !== 4'd10 ||
                o.flat !== {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100}) begin
                fails++;
                $display("FAIL full_drop[%0d]: got %h ok=%0b want %h", k, o, ok, e);
            end
        end
    endtask

    task automatic test_full_insert();
        res_t o, e; bit ok; int l;
        insert_one(8'd55, 5, 3, o, ok, l);
        e = sb.pop_front();
        tests++;
        if (!ok || o !== e || o.drop !== 1'b0 || o.num !== 4'd10 ||
            o.flat !== {8'd20, 8'd30, 8'd40, 8'd50, 8'd55, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100}) begin
            fails++;
            $display("FAIL full_insert: got %h ok=%0b want %h", o, ok, e);
        end
    endtask

    task automatic test_timeout();
        bit ok_a, ok_b, done_seen, buf_bad, rdy_after;
        int to_at, to_cnt;
        done_seen = 1'b0; buf_bad = 1'b0; rdy_after = 1'b0; to_at = 0; to_cnt = 0;
        offer(8'd77, ok_a);
        wait_req(ok_b);
        // k counts cycles spent since WAIT was entered, starting at 1.
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (timeout) begin
                to_cnt++;
                if (to_at == 0) to_at = k;
            end
            if (insert_done) done_seen = 1'b1;
            if (score_buffer !== model_flat()) buf_bad = 1'b1;
            if (k == 17) rdy_after = score_ready;
            @(posedge clk); #1;
        end
        tests++;
        if (!ok_a || !ok_b || to_at != 16 || to_cnt != 1) begin
            fails++;
            $display("FAIL timeout_pulse: got at=%0d count=%0d want at=16 count=1", to_at, to_cnt);
        end
        tests++;
        if (done_seen || buf_bad) begin
            fails++;
            $display("FAIL timeout_buffer: got done=%0b changed=%0b want 0 0", done_seen, buf_bad);
        end
        tests++;
        if (rdy_after !== 1'b1) begin
            fails++;
            $display("FAIL timeout_ready: got %b want 1", rdy_after);
        end
    endtask

    task automatic test_clear_wait();
        bit ok_a, ok_b, done_seen, cdr_seen;
        done_seen = 1'b0; cdr_seen = 1'b0;
        offer(8'd77, ok_a);
        wait_req(ok_b);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear        = 1'b0;
        compare_rdy  = 1'b1;
        insert_index = 4'd0;
        model_clear();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            done_seen |= insert_done;
            cdr_seen  |= compare_data_rdy;
            @(posedge clk); #1;
        end
        compare_rdy = 1'b0;
        tests++;
        if (!ok_a || !ok_b || done_seen || cdr_seen) begin
            fails++;
            $display("FAIL clear_wait_pulses: got done=%0b cdr=%0b want 0 0", done_seen, cdr_seen);
        end
        tests++;
        if (compare_num !== 4'd0 || score_buffer !== '0 || score_ready !== 1'b1) begin
            fails++;
            $display("FAIL clear_wait_state: got num=%0d buf=%h rdy=%b want 0 0 1",
                     compare_num, score_buffer, score_ready);
        end
    endtask

    task automatic test_reset_wait();
        res_t o, e; bit ok, ok_a, ok_b, done_seen; int l;
        done_seen = 1'b0;
        insert_one(8'd44, 0, 0, o, ok, l);
        e = sb.pop_front();
        tests++;
        if (!ok || o !== e) begin
            fails++;
            $display("FAIL pre_reset_insert: got %h ok=%0b want %h", o, ok, e);
        end
        offer(8'd33, ok_a);
        wait_req(ok_b);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (compare_num !== 4'd0 || score_buffer !== '0 || score_out !== '0 || compare_data_rdy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got num=%0d buf=%h out=%0d cdr=%b want 0 0 0 0",
                     compare_num, score_buffer, score_out, compare_data_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        compare_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            done_seen |= insert_done;
            @(posedge clk); #1;
        end
        compare_rdy = 1'b0;
        tests++;
        if (!ok_a || !ok_b || done_seen || compare_num !== 4'd0) begin
            fails++;
            $display("FAIL reset_wait_discard: got done=%0b num=%0d want 0 0", done_seen, compare_num);
        end
    endtask

    task automatic test_back_to_back();
        res_t o, e; bit ok; int l, lat, ii;
        logic [W-1:0] s;
        do_clear();
        for (int k = 0; k < 14; k++) begin
            s   = 8'($urandom_range(1, 255));
            ii  = $urandom_range(0, 11);
            lat = $urandom_range(0, 6);
            insert_one(s, ii, lat, o, ok, l);
            e = sb.pop_front();
            tests++;
            if (!ok || o !== e || l != lat + 3) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %h lat=%0d ok=%0b want %h lat=%0d",
                         k, o, l, ok, e, lat + 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_insert();
        test_mid_insert();
        test_index_clamp();
        test_full_drop();
        test_full_insert();
        test_timeout();
        test_clear_wait();
        test_reset_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rank_insert.md
RANK_INSERT -- requirements
Module: rank_insert

Interface
REQ-001 Parameter width, 8: score bit width.
REQ-002 Parameter quantity, 10: number of ranked entries, at most 15.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port score_valid, input, 1: a new score is offered.
REQ-006 Port score_in, input, width: the offered score.
REQ-007 Port score_ready, output, 1: the block accepts a score this cycle.
REQ-008 Port clear, input, 1: synchronous flush of the ranked buffer.
REQ-009 Port compare_data_rdy, output, 1: one-cycle start pulse to the downstream comparator.
REQ-010 Port score_out, output, width: the latched score presented to the comparator.
REQ-011 Port score_buffer, output, quantity*width: ranked entries, entry j at bits [j*width +: width], entry 0 highest.
REQ-012 Port compare_num, output, 4: count of valid entries (0..quantity).
REQ-013 Port compare_rdy, input, 1: comparator result valid.
REQ-014 Port insert_index, input, 4: insert position from the comparator, sampled only while compare_rdy=1.
REQ-015 Port insert_done, output, 1: one-cycle pulse when a score has been inserted or dropped.
REQ-016 Port dropped, output, 1: qualifies insert_done; the score ranked below all entries of a full buffer.
REQ-017 Port timeout, output, 1: one-cycle pulse when the comparator fails to answer.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-019 In IDLE, score_ready SHALL be 1 and clear SHALL be 0; score_ready SHALL be 0 in every other state.
REQ-020 A handshake (score_valid&score_ready) SHALL latch score_in into score_out and move the FSM to REQ.
REQ-021 In REQ, compare_data_rdy SHALL be 1 for exactly one cycle; the FSM SHALL then go to WAIT with the 4-bit wait counter at 0.
REQ-022 In WAIT, score_buffer, compare_num and score_out SHALL be held stable.
REQ-023 In WAIT, when compare_rdy=1: let idx = min(insert_index, compare_num).
REQ-024 If idx < quantity, then buf[j] <= buf[j-1] for idx<j<quantity, buf[idx] <= score_out, the last entry is discarded, and compare_num <= min(compare_num+1, quantity).
REQ-025 If insert_index >= quantity, the buffer SHALL be left unchanged and dropped SHALL be set.
REQ-026 After REQ-024 or REQ-025 the FSM SHALL go to DONE.
REQ-027 In DONE, insert_done SHALL be 1 for one cycle (dropped valid with it), then the FSM SHALL return to IDLE; the accept-to-done latency is compare latency + 3 cycles.
REQ-028 In WAIT, the wait counter SHALL increment each cycle without compare_rdy; on reaching 15, the block SHALL pulse timeout, leave the buffer unchanged and return to IDLE.
REQ-029 Entries with index >= compare_num SHALL read as 0.
REQ-030 clear in IDLE or DONE SHALL zero all entries and compare_num next cycle; in DONE, insert_done still pulses.
REQ-031 clear in REQ or WAIT SHALL abort to IDLE, zero the buffer, suppress insert_done, and not pulse compare_data_rdy again.
REQ-032 compare_rdy outside WAIT SHALL be ignored.
REQ-033 Equal scores SHALL insert at the index returned, after existing equals.

Reset
REQ-034 rst=1 SHALL asynchronously force IDLE, zero all entries, set compare_num=0, score_out=0, and set compare_data_rdy, insert_done, dropped and timeout to 0.
REQ-035 Reset mid-WAIT SHALL discard the pending score.

Structure
REQ-036 Package rank_pkg SHALL hold the FSM state type, IDX_W=4, TIMEOUT=15 and the default width/quantity constants.
REQ-037 The shift/insert datapath SHALL be one sub-module, rank_insert_shift (inputs buf, idx, score, wr_en; output next buf).

Verification
REQ-038 Empty buffer, score 50, comparator returns 0 -> entry0=50, compare_num=1, insert_done with dropped=0.
REQ-039 Buffer {90,70,40}, score 60, index 2 -> buffer {90,70,60,40}, compare_num=4.
REQ-040 Full buffer {100..10 step 10}, score 5, index 10 -> buffer unchanged, dropped=1, compare_num=10.
REQ-041 Full buffer, score 55, index 5 -> 55 at entry 5, old 10 discarded, compare_num stays 10.
REQ-042 compare_rdy withheld -> timeout pulse 15 cycles after entering WAIT, buffer unchanged, score_ready=1 the following cycle.
REQ-043 clear asserted during WAIT, then compare_rdy -> buffer zeroed, no insert_done, compare_rdy ignored.
